// File: rtl/pipeline_stage_chain.sv
// pipeline_stage_chain
//   Chain of DEPTH elastic register stages with per-stage valid bits and a
//   combinational valid/ready backpressure path. Used as a stallable, flushable
//   delay line between multi-cycle datapath units.
//
//   Parameters
//     WIDTH        data width in bits (>= 1)
//     DEPTH        number of register stages (>= 1); nominal latency in cycles
//     RESET_VALUE  value loaded into every data register on Reset
//                  (zero-extended or truncated to WIDTH)
//
//   Ports
//     CLK        in   clock, all state updates on the rising edge
//     Reset      in   synchronous active-high reset, dominates flush
//     flush      in   synchronous clear of every stage valid bit
//     in_valid   in   upstream word present on in_data
//     in_data    in   upstream data
//     in_ready   out  chain accepts in_data this cycle (combinational)
//     out_valid  out  last stage holds a valid word
//     out_data   out  last stage data
//     out_ready  in   downstream accepts out_data this cycle
//     occupancy  out  registered count of valid stages (PIPE_OCCUPANCY_EN only)
//
//   Build option
//     PIPE_OCCUPANCY_EN  adds the occupancy port and its counter.
module pipeline_stage_chain #(
    parameter int unsigned WIDTH       = 16,
    parameter int unsigned DEPTH       = 2,
    parameter              RESET_VALUE = 16'h0
) (
    input  logic                         CLK,
    input  logic                         Reset,
    input  logic                         flush,
    input  logic                         in_valid,
    input  logic [WIDTH-1:0]             in_data,
    output logic                         in_ready,
    output logic                         out_valid,
    output logic [WIDTH-1:0]             out_data,
`ifdef PIPE_OCCUPANCY_EN
    input  logic                         out_ready,
    output logic [$clog2(DEPTH+1)-1:0]   occupancy
`else
    input  logic                         out_ready
`endif
);

    localparam logic [WIDTH-1:0] RESET_DATA = WIDTH'(RESET_VALUE);

    logic [WIDTH-1:0] data_q [DEPTH];
    logic [DEPTH-1:0] valid_q;
    logic [DEPTH-1:0] rdy_c;
    logic             rdy_acc_c;
    logic             in_fire_c;

    // Ready ripples from the output toward the input: a stage may load when the
    // stage after it can load or when it is itself empty. The running OR is kept
    // in a scalar so rdy_c never depends on its own bits.
    always_comb begin
        rdy_c          = '0;
        rdy_acc_c      = out_ready | ~valid_q[DEPTH-1];
        rdy_c[DEPTH-1] = rdy_acc_c;
        for (int unsigned k = 1; k < DEPTH; k++) begin
            rdy_acc_c            = rdy_acc_c | ~valid_q[DEPTH-1-k];
            rdy_c[DEPTH-1-k]     = rdy_acc_c;
        end
    end

    assign in_ready  = rdy_c[0] & ~flush & ~Reset;
    assign in_fire_c = in_valid & in_ready;

    // Valid bits: cleared by Reset or flush, otherwise shift where ready.
    always_ff @(posedge CLK) begin
        if (Reset || flush) begin
            valid_q <= '0;
        end else begin
            if (rdy_c[0]) begin
                valid_q[0] <= in_valid;
            end
            for (int unsigned i = 1; i < DEPTH; i++) begin
                if (rdy_c[i]) begin
                    valid_q[i] <= valid_q[i-1];
                end
            end
        end
    end

    // Data registers: only move real words, so an empty stage keeps its old
    // contents (RESET_VALUE after Reset) and flush leaves data untouched.
    always_ff @(posedge CLK) begin
        if (Reset) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                data_q[i] <= RESET_DATA;
            end
        end else if (!flush) begin
            if (in_fire_c) begin
                data_q[0] <= in_data;
            end
            for (int unsigned i = 1; i < DEPTH; i++) begin
                if (rdy_c[i] && valid_q[i-1]) begin
                    data_q[i] <= data_q[i-1];
                end
            end
        end
    end

    assign out_valid = valid_q[DEPTH-1];
    assign out_data  = data_q[DEPTH-1];

`ifdef PIPE_OCCUPANCY_EN
    localparam int unsigned OCC_W = $clog2(DEPTH + 1);

    logic [OCC_W-1:0] occ_q;
    logic             out_fire_c;

    assign out_fire_c = valid_q[DEPTH-1] & out_ready;

    // Word count: up on accept without pop, down on pop without accept.
    always_ff @(posedge CLK) begin
        if (Reset || flush) begin
            occ_q <= '0;
        end else if (in_fire_c && !out_fire_c) begin
            occ_q <= occ_q + OCC_W'(1);
        end else if (!in_fire_c && out_fire_c) begin
            occ_q <= occ_q - OCC_W'(1);
        end
    end

    assign occupancy = occ_q;
`endif

endmodule

// File: tb/tb_pipeline_stage_chain.sv
// Self-checking bench for pipeline_stage_chain: directed scenarios on a
// WIDTH=16/DEPTH=2 instance, randomized valid/ready traffic on DEPTH=1/3/4
// instances with WIDTH=8/16 checked against a word-order scoreboard.
module tb_pipeline_stage_chain;

    localparam int unsigned D  = 2;
    localparam logic [15:0] RV = 16'hC3A5;

    logic CLK = 1'b0;
    always #5 CLK = ~CLK;

    int n_checks = 0;
    int n_fail   = 0;

    logic        Reset;
    logic        flush;

    // Main instance
    logic        m_in_valid, m_out_ready, m_in_ready, m_out_valid;
    logic [15:0] m_in_data, m_out_data;

    // Random-traffic instances: index 0 -> DEPTH 1 W8, 1 -> DEPTH 3 W16, 2 -> DEPTH 4 W8
    logic [2:0]  r_in_valid, r_out_ready;
    logic [15:0] r_in_data;
    logic        d1_in_ready, d3_in_ready, d4_in_ready;
    logic        d1_out_valid, d3_out_valid, d4_out_valid;
    logic [7:0]  d1_out_data, d4_out_data;
    logic [15:0] d3_out_data;
    logic [2:0]  r_ir, r_ov;
    logic [15:0] r_od [3];

`ifdef PIPE_OCCUPANCY_EN
    logic [1:0]  m_occ;
    logic [0:0]  d1_occ;
    logic [1:0]  d3_occ;
    logic [2:0]  d4_occ;
    logic [2:0]  r_occ [3];
`endif

    pipeline_stage_chain #(.WIDTH(16), .DEPTH(D), .RESET_VALUE(RV)) u_main (
        .CLK(CLK), .Reset(Reset), .flush(flush),
        .in_valid(m_in_valid), .in_data(m_in_data), .in_ready(m_in_ready),
        .out_valid(m_out_valid), .out_data(m_out_data),
`ifdef PIPE_OCCUPANCY_EN
        .occupancy(m_occ),
`endif
        .out_ready(m_out_ready));

    pipeline_stage_chain #(.WIDTH(8), .DEPTH(1)) u_d1 (
        .CLK(CLK), .Reset(Reset), .flush(1'b0),
        .in_valid(r_in_valid[0]), .in_data(r_in_data[7:0]), .in_ready(d1_in_ready),
        .out_valid(d1_out_valid), .out_data(d1_out_data),
`ifdef PIPE_OCCUPANCY_EN
        .occupancy(d1_occ),
`endif
        .out_ready(r_out_ready[0]));

    pipeline_stage_chain #(.WIDTH(16), .DEPTH(3), .RESET_VALUE(16'hFACE)) u_d3 (
        .CLK(CLK), .Reset(Reset), .flush(1'b0),
        .in_valid(r_in_valid[1]), .in_data(r_in_data), .in_ready(d3_in_ready),
        .out_valid(d3_out_valid), .out_data(d3_out_data),
`ifdef PIPE_OCCUPANCY_EN
        .occupancy(d3_occ),
`endif
        .out_ready(r_out_ready[1]));

    pipeline_stage_chain #(.WIDTH(8), .DEPTH(4), .RESET_VALUE(16'h1234)) u_d4 (
        .CLK(CLK), .Reset(Reset), .flush(1'b0),
        .in_valid(r_in_valid[2]), .in_data(r_in_data[7:0]), .in_ready(d4_in_ready),
        .out_valid(d4_out_valid), .out_data(d4_out_data),
`ifdef PIPE_OCCUPANCY_EN
        .occupancy(d4_occ),
`endif
        .out_ready(r_out_ready[2]));

    always_comb begin
        r_ir    = {d4_in_ready, d3_in_ready, d1_in_ready};
        r_ov    = {d4_out_valid, d3_out_valid, d1_out_valid};
        r_od[0] = {8'h00, d1_out_data};
        r_od[1] = d3_out_data;
        r_od[2] = {8'h00, d4_out_data};
`ifdef PIPE_OCCUPANCY_EN
        r_occ[0] = {2'b00, d1_occ};
        r_occ[1] = {1'b0, d3_occ};
        r_occ[2] = d4_occ;
`endif
    end

    task automatic test_reset();
        Reset = 1'b1; flush = 1'b0;
        m_in_valid = 1'b1; m_in_data = 16'h1234; m_out_ready = 1'b1;
        r_in_valid = 3'b111; r_in_data = 16'hFFFF; r_out_ready = 3'b111;
        repeat (2) begin
            @(posedge CLK); #1;
            @(negedge CLK);
            n_checks++; if (m_out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got %b want 0", m_out_valid); end
            n_checks++; if (m_out_data !== RV) begin n_fail++; $display("FAIL reset_out_data got %h want %h", m_out_data, RV); end
            n_checks++; if (m_in_ready !== 1'b0) begin n_fail++; $display("FAIL reset_in_ready got %b want 0", m_in_ready); end
            n_checks++; if (r_ov !== 3'b000) begin n_fail++; $display("FAIL reset_rand_out_valid got %b want 000", r_ov); end
            n_checks++; if (d4_out_data !== 8'h34) begin n_fail++; $display("FAIL reset_trunc_value got %h want 34", d4_out_data); end
            n_checks++; if (d3_out_data !== 16'hFACE) begin n_fail++; $display("FAIL reset_d3_value got %h want face", d3_out_data); end
`ifdef PIPE_OCCUPANCY_EN
            n_checks++; if (m_occ !== 2'd0) begin n_fail++; $display("FAIL reset_occupancy got %0d want 0", m_occ); end
`endif
        end
        @(posedge CLK); #1;
        Reset = 1'b0; m_in_valid = 1'b0; r_in_valid = 3'b000;
        @(negedge CLK);
        n_checks++; if (m_in_ready !== 1'b1) begin n_fail++; $display("FAIL post_reset_in_ready got %b want 1", m_in_ready); end
        n_checks++; if (m_out_data !== RV || m_out_valid !== 1'b0) begin n_fail++; $display("FAIL post_reset_out got %b/%h want 0/%h", m_out_valid, m_out_data, RV); end
        @(posedge CLK); #1;
    endtask

    // With out_ready high a word accepted in iteration k is visible in iteration k+D.
    task automatic test_streaming();
        logic [15:0] acc_data[$];
        int          acc_iter[$];
        int          n_seen = 0;
        m_out_ready = 1'b1;
        for (int c = 0; c < 9; c++) begin
            m_in_valid = (c < 5);
            m_in_data  = 16'(c + 1);
            @(negedge CLK);
            if (m_out_valid === 1'b1) n_seen++;
            n_checks++; if (m_in_ready !== 1'b1) begin n_fail++; $display("FAIL stream_in_ready c=%0d got %b want 1", c, m_in_ready); end
            if (acc_iter.size() != 0 && acc_iter[0] + int'(D) == c) begin
                n_checks++; if (m_out_valid !== 1'b1 || m_out_data !== acc_data[0]) begin n_fail++; $display("FAIL stream_out c=%0d got %b/%h want 1/%h", c, m_out_valid, m_out_data, acc_data[0]); end
                void'(acc_data.pop_front()); void'(acc_iter.pop_front());
            end else begin
                n_checks++; if (m_out_valid !== 1'b0) begin n_fail++; $display("FAIL stream_gap c=%0d got out_valid %b want 0", c, m_out_valid); end
            end
            if (m_in_valid) begin acc_data.push_back(m_in_data); acc_iter.push_back(c); end
            @(posedge CLK); #1;
        end
        n_checks++; if (n_seen != 5) begin n_fail++; $display("FAIL stream_count got %0d want 5", n_seen); end
    endtask

    task automatic test_backpressure();
        logic [15:0] w [3];
        int idx  = 0;
        int nout = 0;
        w[0] = 16'h1111; w[1] = 16'h2222; w[2] = 16'h3333;
        m_out_ready = 1'b0;
        for (int c = 0; c < 5; c++) begin
            m_in_valid = 1'b1;
            m_in_data  = w[idx];
            @(negedge CLK);
            n_checks++; if (m_in_ready !== (c < int'(D))) begin n_fail++; $display("FAIL bp_in_ready c=%0d got %b want %b", c, m_in_ready, (c < int'(D))); end
            if (c >= int'(D)) begin
                n_checks++; if (m_out_valid !== 1'b1 || m_out_data !== w[0]) begin n_fail++; $display("FAIL bp_hold c=%0d got %b/%h want 1/%h", c, m_out_valid, m_out_data, w[0]); end
            end
            if (c < int'(D)) idx++;
            @(posedge CLK); #1;
        end
`ifdef PIPE_OCCUPANCY_EN
        @(negedge CLK);
        n_checks++; if (m_occ !== 2'd2) begin n_fail++; $display("FAIL bp_occupancy got %0d want 2", m_occ); end
        @(posedge CLK); #1;
`endif
        m_out_ready = 1'b1;
        m_in_valid  = 1'b1;
        m_in_data   = w[2];
        for (int c = 0; c < 8; c++) begin
            @(negedge CLK);
            if (c == 0) begin
                n_checks++; if (m_in_ready !== 1'b1) begin n_fail++; $display("FAIL bp_release_in_ready got %b want 1", m_in_ready); end
            end
            if (m_out_valid && m_out_ready) begin
                n_checks++;
                if (nout >= 3) begin n_fail++; $display("FAIL bp_extra_word got %h want none", m_out_data); end
                else if (m_out_data !== w[nout]) begin n_fail++; $display("FAIL bp_order n=%0d got %h want %h", nout, m_out_data, w[nout]); end
                nout++;
            end
            if (m_in_valid && m_in_ready) idx++;
            @(posedge CLK); #1;
            m_in_valid = (idx < 3);
            m_in_data  = (idx < 3) ? w[idx] : 16'h0000;
        end
        n_checks++; if (nout != 3) begin n_fail++; $display("FAIL bp_delivered got %0d want 3", nout); end
    endtask

    task automatic test_full_pop_push();
        m_out_ready = 1'b0;
        m_in_valid = 1'b1; m_in_data = 16'hAAA1;
        @(posedge CLK); #1;
        m_in_data = 16'hAAA2;
        @(posedge CLK); #1;
        m_in_data = 16'hAAA3; m_out_ready = 1'b1;
        @(negedge CLK);
        n_checks++; if (m_in_ready !== 1'b1) begin n_fail++; $display("FAIL fpp_in_ready got %b want 1", m_in_ready); end
        n_checks++; if (m_out_valid !== 1'b1 || m_out_data !== 16'hAAA1) begin n_fail++; $display("FAIL fpp_pop got %b/%h want 1/aaa1", m_out_valid, m_out_data); end
        @(posedge CLK); #1;
        m_in_valid = 1'b0; m_out_ready = 1'b0;
        @(negedge CLK);
        n_checks++; if (m_out_valid !== 1'b1 || m_out_data !== 16'hAAA2) begin n_fail++; $display("FAIL fpp_next got %b/%h want 1/aaa2", m_out_valid, m_out_data); end
        n_checks++; if (m_in_ready !== 1'b0) begin n_fail++; $display("FAIL fpp_full_in_ready got %b want 0", m_in_ready); end
`ifdef PIPE_OCCUPANCY_EN
        n_checks++; if (m_occ !== 2'd2) begin n_fail++; $display("FAIL fpp_occupancy got %0d want 2", m_occ); end
`endif
        @(posedge CLK); #1;
        m_out_ready = 1'b1;
        @(negedge CLK);
        n_checks++; if (m_out_valid !== 1'b1 || m_out_data !== 16'hAAA2) begin n_fail++; $display("FAIL fpp_drain1 got %b/%h want 1/aaa2", m_out_valid, m_out_data); end
        @(posedge CLK); #1;
        @(negedge CLK);
        n_checks++; if (m_out_valid !== 1'b1 || m_out_data !== 16'hAAA3) begin n_fail++; $display("FAIL fpp_drain2 got %b/%h want 1/aaa3", m_out_valid, m_out_data); end
        @(posedge CLK); #1;
        @(negedge CLK);
        n_checks++; if (m_out_valid !== 1'b0) begin n_fail++; $display("FAIL fpp_empty got %b want 0", m_out_valid); end
        @(posedge CLK); #1;
    endtask

    task automatic test_flush();
        m_out_ready = 1'b1;
        m_in_valid = 1'b1; m_in_data = 16'h0A0A;
        @(posedge CLK); #1;
        m_in_data = 16'h0B0B;
        @(posedge CLK); #1;
        flush = 1'b1; m_in_data = 16'hBEEF;
        @(negedge CLK);
        n_checks++; if (m_in_ready !== 1'b0) begin n_fail++; $display("FAIL flush_in_ready got %b want 0", m_in_ready); end
        n_checks++; if (m_out_valid !== 1'b1 || m_out_data !== 16'h0A0A) begin n_fail++; $display("FAIL flush_delivered got %b/%h want 1/0a0a", m_out_valid, m_out_data); end
        @(posedge CLK); #1;
        flush = 1'b0; m_in_valid = 1'b0;
        @(negedge CLK);
        n_checks++; if (m_in_ready !== 1'b1) begin n_fail++; $display("FAIL flush_after_in_ready got %b want 1", m_in_ready); end
`ifdef PIPE_OCCUPANCY_EN
        n_checks++; if (m_occ !== 2'd0) begin n_fail++; $display("FAIL flush_occupancy got %0d want 0", m_occ); end
`endif
        for (int c = 0; c < 5; c++) begin
            n_checks++; if (m_out_valid !== 1'b0) begin n_fail++; $display("FAIL flush_leak c=%0d got %b/%h want 0", c, m_out_valid, m_out_data); end
            @(posedge CLK); #1;
            @(negedge CLK);
        end
        @(posedge CLK); #1;
    endtask

    task automatic test_reset_midstream();
        m_out_ready = 1'b1;
        m_in_valid = 1'b1; m_in_data = 16'h7777;
        @(posedge CLK); #1;
        m_in_data = 16'h8888;
        @(posedge CLK); #1;
        Reset = 1'b1; m_in_data = 16'h9999;
        @(negedge CLK);
        n_checks++; if (m_in_ready !== 1'b0) begin n_fail++; $display("FAIL midrst_in_ready got %b want 0", m_in_ready); end
        @(posedge CLK); #1;
        Reset = 1'b0; m_in_valid = 1'b0;
        for (int c = 0; c < 4; c++) begin
            @(negedge CLK);
            n_checks++; if (m_out_valid !== 1'b0 || m_out_data !== RV) begin n_fail++; $display("FAIL midrst_out c=%0d got %b/%h want 0/%h", c, m_out_valid, m_out_data, RV); end
            @(posedge CLK); #1;
        end
    endtask

    // Scoreboard: words must leave in accept order; chain can take a word
    // exactly when it holds fewer than DEPTH words or the output pops.
    task automatic test_random_traffic();
        logic [15:0] sb [3][$];
        int          depth_of [3];
        logic [15:0] mask_of [3];
        logic        prev_stall [3];
        logic [15:0] prev_data [3];
        localparam int N = 900;
        depth_of[0] = 1; depth_of[1] = 3; depth_of[2] = 4;
        mask_of[0] = 16'h00FF; mask_of[1] = 16'hFFFF; mask_of[2] = 16'h00FF;
        for (int d = 0; d < 3; d++) begin prev_stall[d] = 1'b0; prev_data[d] = 16'h0; end
        for (int cyc = 0; cyc < N; cyc++) begin
            if (cyc >= N - 12) begin
                r_in_valid  = 3'b000;
                r_out_ready = 3'b111;
            end else begin
                r_in_valid = 3'($urandom);
                for (int d = 0; d < 3; d++)
                    r_out_ready[d] = ($urandom_range(0, 9) < ((cyc / 150) % 2 == 0 ? 7 : 3));
            end
            r_in_data = 16'($urandom);
            @(negedge CLK);
            for (int d = 0; d < 3; d++) begin
                if (prev_stall[d]) begin
                    n_checks++; if (r_ov[d] !== 1'b1 || r_od[d] !== prev_data[d]) begin n_fail++; $display("FAIL rnd_stable dut=%0d cyc=%0d got %b/%h want 1/%h", d, cyc, r_ov[d], r_od[d], prev_data[d]); end
                end
                n_checks++; if (r_ir[d] !== (r_out_ready[d] || sb[d].size() < depth_of[d])) begin n_fail++; $display("FAIL rnd_in_ready dut=%0d cyc=%0d got %b want %b", d, cyc, r_ir[d], (r_out_ready[d] || sb[d].size() < depth_of[d])); end
                if (sb[d].size() == 0) begin
                    n_checks++; if (r_ov[d] !== 1'b0) begin n_fail++; $display("FAIL rnd_phantom dut=%0d cyc=%0d got out_valid %b want 0", d, cyc, r_ov[d]); end
                end
`ifdef PIPE_OCCUPANCY_EN
                n_checks++; if (int'(r_occ[d]) != sb[d].size()) begin n_fail++; $display("FAIL rnd_occupancy dut=%0d cyc=%0d got %0d want %0d", d, cyc, r_occ[d], sb[d].size()); end
`endif
                if (r_ov[d] && r_out_ready[d]) begin
                    n_checks++;
                    if (sb[d].size() == 0) begin n_fail++; $display("FAIL rnd_underflow dut=%0d cyc=%0d got %h want none", d, cyc, r_od[d]); end
                    else begin
                        if (r_od[d] !== sb[d][0]) begin n_fail++; $display("FAIL rnd_order dut=%0d cyc=%0d got %h want %h", d, cyc, r_od[d], sb[d][0]); end
                        void'(sb[d].pop_front());
                    end
                end
                if (r_in_valid[d] && r_ir[d]) sb[d].push_back(r_in_data & mask_of[d]);
                prev_stall[d] = r_ov[d] & ~r_out_ready[d];
                prev_data[d]  = r_od[d];
            end
            @(posedge CLK); #1;
        end
        for (int d = 0; d < 3; d++) begin
            n_checks++; if (sb[d].size() != 0) begin n_fail++; $display("FAIL rnd_lost dut=%0d got %0d words left want 0", d, sb[d].size()); end
        end
    endtask

    initial begin
        test_reset();
        test_streaming();
        test_backpressure();
        test_full_pop_push();
        test_flush();
        test_reset_midstream();
        test_random_traffic();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog time limit reached after %0d checks", n_checks);
        $fatal(1, "watchdog");
    end

endmodule
